shift_step_ctrl: RTL and testbench



---
 rtl/shift_pkg.sv | 16 +
 rtl/key_debounce.sv | 29 ++
 rtl/shift_step_ctrl.sv | 62 ++++++
 tb/tb_shift_step_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: mode codes and select type shared by the step controller and the shift stage
package shift_pkg;
  typedef logic [3:0] sel_t;
  typedef enum logic [3:0] {
    SEL_CLR  = 4'd0,
    SEL_LOAD = 4'd1,
    SEL_SRL  = 4'd2,
    SEL_SLL  = 4'd3,
    SEL_SRA  = 4'd4,
    SEL_SRIN = 4'd5,
    SEL_ROR  = 4'd6,
    SEL_ROL  = 4'd7,
    SEL_RAND = 4'd8
  } sel_code_e;
  localparam sel_t SEL_MAX = 4'd8;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer, stability counter and one-cycle press pulse for an active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level, done;
  logic [CW-1:0] cnt;
  assign done = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      cnt   <= (s2 == level || done) ? '0 : cnt + 1'b1;
      level <= done ? s2 : level;
      press <= done && !s2;
    end
  end
endmodule

// File: rtl/shift_step_ctrl.sv
// shift_step_ctrl: turns debounced key presses or an auto-run timer into step_en pulses with a captured mode bundle
module shift_step_ctrl
  import shift_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_PERIOD     = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_step,
  input  logic       key_auto,
  input  logic [3:0] sw_mode,
  input  logic [7:0] sw_data,
  input  logic       sw_left,
  output logic       step_en,
  output logic [3:0] select,
  output logic [7:0] in_data,
  output logic       in_left,
  output logic       auto_on,
  output logic       bad_mode
);
  localparam int TW = $clog2(AUTO_PERIOD);
  logic step_press, auto_press, tick, wrap, req, ok, issue, auto_nxt;
  logic [TW-1:0] tmr;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(clk), .rst_n(rst_n), .key(key_step), .press(step_press)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
    .clk(clk), .rst_n(rst_n), .key(key_auto), .press(auto_press)
  );
  assign wrap = tmr == TW'(AUTO_PERIOD - 1);
  // a toggle press beats a coincident timer tick; clear/load end auto-run after one step
  always_comb begin
    req      = auto_on ? tick && !auto_press : step_press;
    ok       = sw_mode <= SEL_MAX;
    issue    = req && ok;
    auto_nxt = auto_press ? !auto_on : auto_on && !(issue && sw_mode <= sel_t'(SEL_LOAD));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr      <= '0;
      tick     <= 1'b0;
      auto_on  <= 1'b0;
      step_en  <= 1'b0;
      bad_mode <= 1'b0;
      select   <= '0;
      in_data  <= '0;
      in_left  <= 1'b0;
    end else begin
      tmr      <= (!auto_on || auto_press || wrap) ? '0 : tmr + 1'b1;
      tick     <= auto_on && wrap;
      auto_on  <= auto_nxt;
      step_en  <= issue;
      bad_mode <= req && !ok;
      if (issue) begin
        select  <= sw_mode;
        in_data <= sw_data;
        in_left <= sw_left;
      end
    end
  end
endmodule

// File: tb/tb_shift_step_ctrl.sv
// tb_shift_step_ctrl: directed vector table plus hand-written auto-run and reset sequences
module tb_shift_step_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, key_step = 1'b1, key_auto = 1'b1, sw_left = 1'b0;
  logic [3:0] sw_mode = '0;
  logic [7:0] sw_data = '0;
  logic step_en, in_left, auto_on, bad_mode;
  logic [3:0] select;
  logic [7:0] in_data;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  shift_step_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(10)) dut (
    .clk(clk), .rst_n(rst_n), .key_step(key_step), .key_auto(key_auto),
    .sw_mode(sw_mode), .sw_data(sw_data), .sw_left(sw_left),
    .step_en(step_en), .select(select), .in_data(in_data), .in_left(in_left),
    .auto_on(auto_on), .bad_mode(bad_mode)
  );
  typedef struct {
    logic       ks;
    logic [3:0] mode;
    logic [7:0] data;
    logic       left;
    int         n;
    logic       e_step;
    logic [3:0] e_sel;
    logic [7:0] e_data;
    logic       e_left;
    logic       e_bad;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic e_step, input logic [3:0] e_sel,
                         input logic [7:0] e_data, input logic e_left, input logic e_auto,
                         input logic e_bad);
    chk({tag, ".step_en"}, step_en, e_step);
    chk({tag, ".select"}, select, e_sel);
    chk({tag, ".in_data"}, in_data, e_data);
    chk({tag, ".in_left"}, in_left, e_left);
    chk({tag, ".auto_on"}, auto_on, e_auto);
    chk({tag, ".bad_mode"}, bad_mode, e_bad);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // manual press: key falls before edge 1, step_en after edge 7; then an illegal code
    tbl[0] = '{1'b0, 4'd1,  8'hA5, 1'b1, 6, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'd1,  8'hA5, 1'b1, 1, 1'b1, 4'd1, 8'hA5, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'd3,  8'h3C, 1'b0, 3, 1'b0, 4'd1, 8'hA5, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 4'd3,  8'h3C, 1'b0, 7, 1'b0, 4'd1, 8'hA5, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'd12, 8'hFF, 1'b0, 6, 1'b0, 4'd1, 8'hA5, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'd12, 8'hFF, 1'b0, 1, 1'b0, 4'd1, 8'hA5, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 4'd12, 8'hFF, 1'b0, 2, 1'b0, 4'd1, 8'hA5, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 4'd12, 8'hFF, 1'b0, 8, 1'b0, 4'd1, 8'hA5, 1'b1, 1'b0};
    repeat (3) cyc();
    chk_out("reset", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    foreach (tbl[r])
      for (int k = 0; k < tbl[r].n; k++) begin
        key_step = tbl[r].ks;
        sw_mode  = tbl[r].mode;
        sw_data  = tbl[r].data;
        sw_left  = tbl[r].left;
        cyc();
        chk_out($sformatf("vec%0d.%0d", r, k), tbl[r].e_step, tbl[r].e_sel, tbl[r].e_data,
                tbl[r].e_left, 1'b0, tbl[r].e_bad);
      end
    sw_mode = 4'd2;
    for (int c = 0; c < 28; c++) begin
      key_step = (c < 20) ? logic'((c / 2) % 2) : 1'b1;
      cyc();
      chk($sformatf("bounce%0d.step_en", c), step_en, 1'b0);
      chk($sformatf("bounce%0d.bad_mode", c), bad_mode, 1'b0);
    end
    // auto-run: on after edge 7, steps at 18,28,38,48; code 1 at 58 ends auto
    sw_data = 8'h5A;
    sw_left = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      key_auto = (c <= 10) ? 1'b0 : 1'b1;
      key_step = (c >= 20 && c <= 29) ? 1'b0 : 1'b1;
      sw_mode  = (c >= 50) ? 4'd1 : 4'd7;
      cyc();
      chk($sformatf("auto%0d.step_en", c), step_en,
          c == 18 || c == 28 || c == 38 || c == 48 || c == 58);
      chk($sformatf("auto%0d.auto_on", c), auto_on, c >= 7 && c < 58);
      if (c == 18 || c == 58) begin
        chk($sformatf("auto%0d.select", c), select, (c == 58) ? 4'd1 : 4'd7);
        chk($sformatf("auto%0d.in_data", c), in_data, 8'h5A);
      end
    end
    sw_mode = 4'd7;
    sw_data = 8'hC3;
    sw_left = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      key_auto = (c <= 10) ? 1'b0 : 1'b1;
      cyc();
    end
    chk_out("pre_rst", 1'b0, 4'd7, 8'hC3, 1'b1, 1'b1, 1'b0);
    key_step = 1'b0;
    sw_mode  = 4'd4;
    repeat (3) cyc();
    chk("pre_rst.step_en", step_en, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      chk($sformatf("post_rst%0d.step_en", c), step_en, c == 7);
      chk($sformatf("post_rst%0d.auto_on", c), auto_on, 1'b0);
      if (c == 7) chk("post_rst.select", select, 4'd4);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
